// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory controller:
// RV32I load/store funct3 codes, FSM state encoding and byte-lane masks.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] LM_B = 4'b0001;
  localparam logic [3:0] LM_H = 4'b0011;
  localparam logic [3:0] LM_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Stores only have the three signed encodings; loads add the unsigned pair.
  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!wr) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the EX/MEM pipeline register and the
// data-memory controller.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_wr, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store write mask / merged word,
// sign- or zero-extended load value and the misalignment flag.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] st_rep;
  logic [31:0] shifted;

  always_comb begin
    wr_mask    = '0;
    st_rep     = st_data;
    misaligned = 1'b0;
    shifted    = rd_word >> {lane, 3'b000};
    ld_data    = shifted;
    case (funct3[1:0])
      2'b00: begin
        wr_mask = LM_B << lane;
        st_rep  = {4{st_data[7:0]}};
        ld_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        wr_mask    = LM_H << lane;
        st_rep     = {2{st_data[15:0]}};
        misaligned = lane[0];
        ld_data    = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        wr_mask    = LM_W;
        misaligned = (lane != 2'b00);
      end
      default: ;
    endcase
    // Unselected lanes carry the current word so a full-word write is also safe.
    wr_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (wr_mask[i]) wr_word[8*i +: 8] = st_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: valid/ready request, configurable wait
// latency, RV32I sub-word loads/stores and fault detection. Falling-edge clocked.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [2:0] CNT_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_wr;
  logic [2:0]        acc_f3;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_oob;
  logic              acc_err;
  logic [DATA_W-1:0] rd_word;
  logic [3:0]        wr_mask;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] ld_data;
  logic              misaligned;
  logic              mem_we;

  // In IDLE the access is taken straight from the bus so LATENCY=0 can commit on accept.
  always_comb begin
    acc_wr    = (state_q == IDLE) ? bus.req_wr     : wr_q;
    acc_f3    = (state_q == IDLE) ? bus.req_funct3 : f3_q;
    acc_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
    acc_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
    acc_idx   = acc_addr[IDX_W+1:2];
    acc_oob   = {2'b00, acc_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);
    rd_word   = mem_q[acc_idx];
    acc_err   = misaligned || acc_oob || !f3_legal(acc_wr, acc_f3);
  end

  mem_lane_align u_align (
    .funct3     (acc_f3),
    .lane       (acc_addr[1:0]),
    .rd_word    (rd_word),
    .st_data    (acc_wdata),
    .wr_mask    (wr_mask),
    .wr_word    (wr_word),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    rsp_valid_d = (state_q == RESP);
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_wr;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = acc_err;
          cnt_d   = 3'd0;
          if (!acc_err && (LATENCY > 0)) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            mem_we  = !acc_err && acc_wr;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          mem_we  = acc_wr;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_err_d   = err_q;
        rsp_rdata_d = (err_q || wr_q) ? '0 : ld_data;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(negedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem_q[acc_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances at LATENCY 1, 3 and 0,
// driven on the rising edge and sampled on the rising edge (DUT acts on falling).
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v    [3];
  logic        valid_v  [3];
  logic        wr_v     [3];
  logic [2:0]  f3_v     [3];
  logic [31:0] addr_v   [3];
  logic [31:0] wdata_v  [3];
  logic        ready_v  [3];
  logic        rvalid_v [3];
  logic [31:0] rdata_v  [3];
  logic        err_v    [3];
  logic        busy_v   [3];

  int n_chk = 0;
  int n_err = 0;

  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if_l1 ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if_l3 ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if_l0 ();

  assign if_l1.req_valid = valid_v[0];
  assign if_l1.req_wr = wr_v[0];
  assign if_l1.req_funct3 = f3_v[0];
  assign if_l1.req_addr = addr_v[0];
  assign if_l1.req_wdata = wdata_v[0];
  assign ready_v[0] = if_l1.req_ready;
  assign rvalid_v[0] = if_l1.rsp_valid;
  assign rdata_v[0] = if_l1.rsp_rdata;
  assign err_v[0] = if_l1.rsp_err;
  assign busy_v[0] = if_l1.busy;

  assign if_l3.req_valid = valid_v[1];
  assign if_l3.req_wr = wr_v[1];
  assign if_l3.req_funct3 = f3_v[1];
  assign if_l3.req_addr = addr_v[1];
  assign if_l3.req_wdata = wdata_v[1];
  assign ready_v[1] = if_l3.req_ready;
  assign rvalid_v[1] = if_l3.rsp_valid;
  assign rdata_v[1] = if_l3.rsp_rdata;
  assign err_v[1] = if_l3.rsp_err;
  assign busy_v[1] = if_l3.busy;

  assign if_l0.req_valid = valid_v[2];
  assign if_l0.req_wr = wr_v[2];
  assign if_l0.req_funct3 = f3_v[2];
  assign if_l0.req_addr = addr_v[2];
  assign if_l0.req_wdata = wdata_v[2];
  assign ready_v[2] = if_l0.req_ready;
  assign rvalid_v[2] = if_l0.rsp_valid;
  assign rdata_v[2] = if_l0.rsp_rdata;
  assign err_v[2] = if_l0.rsp_err;
  assign busy_v[2] = if_l0.busy;

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(2048), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_v[0]), .bus(if_l1.slave));
  data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(2048), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_v[1]), .bus(if_l3.slave));
  data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(2048), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_v[2]), .bus(if_l0.slave));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request: exp_k is the number of rising edges after the accepting
  // falling edge at which rsp_valid is first seen (LATENCY+2, or 2 on error).
  task automatic do_req(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_k, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
    int guard;
    int k;
    logic got;
    @(posedge clk);
    valid_v[d] = 1'b1; wr_v[d] = w; f3_v[d] = f3; addr_v[d] = a; wdata_v[d] = wd;
    guard = 0;
    while (!ready_v[d] && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 20) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    k = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(posedge clk);
      k++;
      if (k == 1) begin
        valid_v[d] = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy_v[d]}, 32'd1);
        chk({tag, "_ready_low"}, {31'd0, ready_v[d]}, 32'd0);
      end
      if (rvalid_v[d]) got = 1'b1;
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_k));
    chk({tag, "_rdata"}, rdata_v[d], exp_rd);
    chk({tag, "_err"}, {31'd0, err_v[d]}, {31'd0, exp_err});
    @(posedge clk);
    chk({tag, "_pulse_end"}, {31'd0, rvalid_v[d]}, 32'd0);
  endtask

  initial begin
    int n_acc, n_pulse, gap_bad, rdy_bad, last;
    logic acc_now;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b0; valid_v[i] = 1'b0; wr_v[i] = 1'b0;
      f3_v[i] = 3'b000; addr_v[i] = 32'd0; wdata_v[i] = 32'd0;
    end
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), {31'd0, ready_v[i]}, 32'd1);
      chk($sformatf("rst_rvalid%0d", i), {31'd0, rvalid_v[i]}, 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata_v[i], 32'd0);
      chk($sformatf("rst_err%0d", i), {31'd0, err_v[i]}, 32'd0);
      chk($sformatf("rst_busy%0d", i), {31'd0, busy_v[i]}, 32'd0);
    end
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;

    // LATENCY=1 directed vectors
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0, "sw10");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, "lw10");
    do_req(0, 1'b1, 3'b000, 32'h11, 32'h0000005A, 3, 32'h0, 1'b0, "sb11");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEAD5AEF, 1'b0, "lw10_merged");
    do_req(0, 1'b0, 3'b000, 32'h11, 32'h0, 3, 32'h0000005A, 1'b0, "lb11");
    do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFFDE, 1'b0, "lb13");
    do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h000000DE, 1'b0, "lbu13");
    do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFFDEAD, 1'b0, "lh12");
    do_req(0, 1'b0, 3'b101, 32'h12, 32'h0, 3, 32'h0000DEAD, 1'b0, "lhu12");
    do_req(0, 1'b1, 3'b001, 32'h11, 32'h00001234, 2, 32'h0, 1'b1, "sh11_mis");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEAD5AEF, 1'b0, "lw10_kept");
    do_req(0, 1'b0, 3'b010, 32'h2000, 32'h0, 2, 32'h0, 1'b1, "lw_oob");
    do_req(0, 1'b0, 3'b011, 32'h10, 32'h0, 2, 32'h0, 1'b1, "ld_f3_011");
    do_req(0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 2, 32'h0, 1'b1, "st_f3_100");
    do_req(0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, 3, 32'h0, 1'b0, "sh12");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hBEEF5AEF, 1'b0, "lw10_sh");

    // LATENCY=3: reset during WAIT drops the store and the response
    do_req(1, 1'b1, 3'b010, 32'h20, 32'h11111111, 5, 32'h0, 1'b0, "l3_sw_old");
    do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 5, 32'h11111111, 1'b0, "l3_lw_old");
    @(posedge clk);
    valid_v[1] = 1'b1; wr_v[1] = 1'b1; f3_v[1] = 3'b010;
    addr_v[1] = 32'h20; wdata_v[1] = 32'h22222222;
    @(negedge clk);
    @(posedge clk);
    valid_v[1] = 1'b0;
    chk("l3_in_wait_busy", {31'd0, busy_v[1]}, 32'd1);
    @(posedge clk);
    rst_v[1] = 1'b0;
    #1;
    chk("l3_rst_ready", {31'd0, ready_v[1]}, 32'd1);
    chk("l3_rst_busy", {31'd0, busy_v[1]}, 32'd0);
    chk("l3_rst_rvalid", {31'd0, rvalid_v[1]}, 32'd0);
    chk("l3_rst_rdata", rdata_v[1], 32'd0);
    chk("l3_rst_err", {31'd0, err_v[1]}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    rst_v[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      chk("l3_no_stale_rsp", {31'd0, rvalid_v[1]}, 32'd0);
    end
    do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, 5, 32'h11111111, 1'b0, "l3_lw_after_rst");

    // LATENCY=0: req_valid held across 4 back-to-back stores
    n_acc = 0; n_pulse = 0; gap_bad = 0; rdy_bad = 0; last = -1; acc_now = 1'b0;
    @(posedge clk);
    valid_v[2] = 1'b1; wr_v[2] = 1'b1; f3_v[2] = 3'b010;
    addr_v[2] = 32'h0; wdata_v[2] = 32'hA0000000;
    for (int c = 0; c < 12; c++) begin
      if (acc_now) begin
        if (n_acc < 4) begin
          addr_v[2] = 32'(4 * n_acc);
          wdata_v[2] = 32'hA0000000 + 32'(n_acc);
        end else begin
          valid_v[2] = 1'b0;
        end
      end
      acc_now = 1'b0;
      if (rvalid_v[2]) n_pulse++;
      if (ready_v[2] == busy_v[2]) rdy_bad++;
      if (ready_v[2] && valid_v[2]) begin
        if (last >= 0 && (c - last) != 2) gap_bad++;
        last = c;
        n_acc++;
        acc_now = 1'b1;
      end
      @(negedge clk);
      @(posedge clk);
    end
    chk("l0_accepts", 32'(n_acc), 32'd4);
    chk("l0_pulses", 32'(n_pulse), 32'd4);
    chk("l0_accept_gap", 32'(gap_bad), 32'd0);
    chk("l0_ready_vs_busy", 32'(rdy_bad), 32'd0);
    do_req(2, 1'b0, 3'b010, 32'hC, 32'h0, 2, 32'hA0000003, 1'b0, "l0_lw0c");
    do_req(2, 1'b0, 3'b001, 32'h6, 32'h0, 2, 32'hFFFFA000, 1'b0, "l0_lh06");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data-memory controller for the MEM stage. It generalises the single-cycle word memory.
- Width, depth and access latency are parameters.
- Supports the RV32I load/store sub-word types (byte, half-word, word) with byte-lane writes and sign/zero-extending loads.
- Uses a valid/ready request handshake and detects misaligned or out-of-range accesses.
- Sits between the EX/MEM pipeline register and the write-back stage.

Parameters:
DATA_W, 32, data word width in bits; must be 32.
ADDR_W, 32, byte-address width.
DEPTH, 2048, number of DATA_W-bit words in the array.
LATENCY, 1, extra wait cycles before an access completes; legal range 0..7.

Ports:
clk  in  1  clock; all state updates on the falling edge, matching the pipeline.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_wr  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  DATA_W  load result, extended to DATA_W.
rsp_err  out  1  access faulted; qualified by rsp_valid.
busy  out  1  request in flight (state != IDLE).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a falling edge, latch wr, funct3, addr and wdata.
  - Go to WAIT if LATENCY>0 and the request is legal; otherwise go to RESP.
- WAIT:
  - req_ready=0; counter counts 0..LATENCY-1.
  - At the last count, perform the access and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, req_ready=0.
  - Next edge returns to IDLE.
  - No response back-pressure; the consumer must sample on the pulse.
- Latency: request accepted at edge N gives rsp_valid high after edge N+1+LATENCY. Back-to-back throughput is one request per LATENCY+2 cycles.
- Address decode: word index = addr[ADDR_W-1:2], lane = addr[1:0].
- Error conditions (rsp_err=1); the array is unchanged and the response comes after one cycle, skipping WAIT:
  - Half-word access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH.
  - Illegal funct3: load 011/110/111; store >= 011.
  - On an error response, rsp_rdata=0.
- Stores:
  - SB writes byte lane[lane] with wdata[7:0].
  - SH writes lanes {lane+1, lane} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are preserved.
  - The write commits on the edge entering RESP; rsp_rdata=0 for stores.
- Loads:
  - Read the word and extract the byte or half at the lane.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - rsp_rdata is registered and held stable until the next response.
- Memory contents at the edge entering RESP are what the load returns; there is no read-during-write within one controller since only one access is in flight.
- Requests while busy: req_valid is ignored when req_ready=0. The requester must hold the request until accepted.
- Reset mid-operation:
  - Return to IDLE immediately.
  - A store not yet committed is discarded.
  - Any pending response is dropped (rsp_valid=0).
- Counter wrap: the counter is sized for max LATENCY and cleared on entering WAIT. LATENCY=0 never enters WAIT.

Decomposition:
- Shared package (mem_pkg):
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {IDLE, WAIT, RESP}.
  - Lane-mask constants.
- One sub-module: mem_lane_align. Combinational; given funct3, lane, read word and store data, it produces:
  - the 4-bit byte-write mask,
  - the merged write word,
  - the extended load value,
  - the misalignment flag.

Test Plan:
- LATENCY=1. SW 0xDEADBEEF @0x10, then LW @0x10: rsp_valid 3 cycles after each accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- After the previous step, SB 0x5A @0x11, then LW @0x10: result 0xDEAD5AEF. LB @0x11 gives 0x0000005A; LB @0x13 gives 0xFFFFFFDE; LBU @0x13 gives 0x000000DE.
- LH @0x12 gives 0xFFFFDEAD; LHU @0x12 gives 0x0000DEAD.
- SH @0x11 (misaligned): rsp_err=1, rsp_valid 2 cycles after accept; a subsequent LW @0x10 shows the word unchanged.
- LW @ (DEPTH*4) gives rsp_err=1. Load funct3=3'b011 gives rsp_err=1. rsp_rdata=0 for both.
- LATENCY=3. Issue SW, then assert rst_n=0 during WAIT: outputs return to reset values asynchronously, no rsp_valid, and a later LW of that address returns the old data.
- Hold req_valid continuously with 4 requests at LATENCY=0: exactly one accept every 2 cycles, req_ready=0 while busy, 4 rsp_valid pulses.
